control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Microcoded sequencer for the 8-bit CPU. Steps T-states per instruction, decodes the IR opcode into
//  per-cycle control strobes for ALU registers, PC, MAR, RAM, IR and output register, and holds the
//  carry/zero flag register fed by the ALU. Sits beside the bus; drives every load/write enable.
// PARAMETERS
//  OPCODE_W   4   opcode width (IR high nibble)
//  STEP_W     3   T-state counter width; microcode defines T0..T4, T4 is always last
// PORTS
//  clk        in   1  system clock, all state on rising edge
//  clr        in   1  synchronous active-low reset (0 = clear on next rising edge)
//  opcode     in   4  IR[7:4], valid from T2
//  carry_in   in   1  ALU carry
//  zero_in    in   1  ALU zero
//  load_A/load_B/write_A/write_B/write_ALU/subtract  out 1 each  ALU strobes
//  pc_inc/pc_write/jump  out 1 each  PC count / PC->bus / bus->PC
//  mar_load/ram_read/ram_write/ir_load/ir_write/out_load  out 1 each  (ir_write = IR[3:0]->bus)
//  flag_c/flag_z  out 1 each  registered flags
//  step       out  3  current T-state
//  halted     out  1  HALT state
// BEHAVIOUR
//  - Reset: step=0, flag_c=flag_z=0, halted=0; while clr==0 every strobe forced 0.
//  - T0: pc_write+mar_load. T1: ram_read+ir_load+pc_inc. T2..T4 per opcode; after the step marked END,
//    step returns to 0 next edge; T4 always ends. Strobes are combinational from (step, opcode, flags).
//  - 0 NOP: T2 END. 1 LDA: T2 ir_write+mar_load; T3 ram_read+load_A END.
//  - 2 ADD: T2 ir_write+mar_load; T3 ram_read+load_B; T4 write_ALU+load_A+load_flags END.
//  - 3 SUB: as ADD, subtract=1 in T4. 4 STA: T2 ir_write+mar_load; T3 write_A+ram_write END.
//  - 5 LDI: T2 ir_write+load_A END. 6 JMP: T2 ir_write+jump END.
//  - 7 JC / 8 JZ: T2 ir_write+jump only if flag_c / flag_z, END either way.
//  - E OUT: T2 write_A+out_load END. F HLT: T2 no strobes; next edge halted=1, step held at 0.
//  - Opcodes 9..D: treated as NOP.
//  - load_flags internal: at edge with load_flags=1, flag_c<=carry_in, flag_z<=zero_in; else held.
//  - subtract held 1 for whole SUB T4 cycle only; 0 elsewhere.
//  - HALT: all strobes 0, flags frozen, exit only via clr==0.
//  - Invariant: at most one of pc_write/ram_read/write_A/write_B/write_ALU/ir_write per cycle.
//  - Reset mid-instruction: wins over advance; instruction abandoned, no partial flag update.
// CONFIGURATION
//  CTRL_SINGLE_STEP_EN defined: adds inputs step_mode, step_btn (1 bit each). step_mode=1 -> advance
//   only on cycles where step_btn==1 and its previous-cycle sample==0; load/write/inc/jump strobes
//   qualified by advance (zero on stall cycles). step_mode=0 -> free-run. Edge register cleared by clr.
//  Undefined: no extra ports; advances every cycle.
// STRUCTURE
//  control_defs.vh: opcode `defines, T-state constants, microword bit positions, END bit.
//  Sub-module microcode_rom: combinational (opcode, step, flag_c, flag_z) -> microword incl. END.
//  Top holds step counter, flag register, halt bit, output gating.
// TESTING
//  - clr=0 2 cycles then 1 -> step=0, flags 0, strobes 0 during reset; T0 pc_write+mar_load next cycle.
//  - ADD with carry_in=1, zero_in=0 -> T4 write_ALU+load_A; flag_c=1,flag_z=0 after T4; step 0 next.
//  - SUB then JZ with zero_in=1 at T4 -> flag_z=1; JZ T2 asserts jump+ir_write; JC (flag_c=0) -> no jump.
//  - HLT -> halted=1 after T2, strobes 0 for 20 cycles; clr=0 -> halted=0, step=0.
//  - clr=0 in ADD T3 -> next edge step=0, flags unchanged from before ADD.
//  - CTRL_SINGLE_STEP_EN, step_mode=1, step_btn held 1 for 5 cycles -> exactly one advance; strobes 0 otherwise.
//  - Every run: assert bus-driver exclusivity invariant each cycle.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared types for the microcoded CPU sequencer: opcodes, T-states and the microword layout.
package control_unit_pkg;

    localparam int OPCODE_W = 4;
    localparam int STEP_W   = 3;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [STEP_W-1:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_e;

    typedef struct packed {
        logic load_a;
        logic load_b;
        logic write_a;
        logic write_b;
        logic write_alu;
        logic subtract;
        logic pc_inc;
        logic pc_write;
        logic jump;
        logic mar_load;
        logic ram_read;
        logic ram_write;
        logic ir_load;
        logic ir_write;
        logic out_load;
        logic load_flags;
        logic halt;
        logic end_step;
    } microword_t;

endpackage

// File: rtl/control_unit_microcode_rom.sv
// Combinational microcode: (opcode, T-state, flags) -> microword including the END marker.
module microcode_rom
    import control_unit_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  step_e               step,
    input  logic                flag_c,
    input  logic                flag_z,
    output microword_t          uword
);

    // NOTE: every field gets a default first so no path through the case infers a latch.
    always_comb begin
        uword = '0;
        case (step)
            T0: begin
                uword.pc_write = 1'b1;
                uword.mar_load = 1'b1;
            end
            T1: begin
                uword.ram_read = 1'b1;
                uword.ir_load  = 1'b1;
                uword.pc_inc   = 1'b1;
            end
            T2: begin
                case (opcode_e'(opcode))
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        uword.ir_write = 1'b1;
                        uword.mar_load = 1'b1;
                    end
                    OP_LDI: begin
                        uword.ir_write = 1'b1;
                        uword.load_a   = 1'b1;
                        uword.end_step = 1'b1;
                    end
                    OP_JMP: begin
                        uword.ir_write = 1'b1;
                        uword.jump     = 1'b1;
                        uword.end_step = 1'b1;
                    end
                    // Conditional jumps always finish here; the branch only decides the strobes.
                    OP_JC: begin
                        uword.ir_write = flag_c;
                        uword.jump     = flag_c;
                        uword.end_step = 1'b1;
                    end
                    OP_JZ: begin
                        uword.ir_write = flag_z;
                        uword.jump     = flag_z;
                        uword.end_step = 1'b1;
                    end
                    OP_OUT: begin
                        uword.write_a  = 1'b1;
                        uword.out_load = 1'b1;
                        uword.end_step = 1'b1;
                    end
                    OP_HLT: begin
                        uword.halt     = 1'b1;
                        uword.end_step = 1'b1;
                    end
                    default: uword.end_step = 1'b1;
                endcase
            end
            T3: begin
                case (opcode_e'(opcode))
                    OP_LDA: begin
                        uword.ram_read = 1'b1;
                        uword.load_a   = 1'b1;
                        uword.end_step = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        uword.ram_read = 1'b1;
                        uword.load_b   = 1'b1;
                    end
                    OP_STA: begin
                        uword.write_a   = 1'b1;
                        uword.ram_write = 1'b1;
                        uword.end_step  = 1'b1;
                    end
                    default: uword.end_step = 1'b1;
                endcase
            end
            T4: begin
                if (opcode_e'(opcode) == OP_ADD || opcode_e'(opcode) == OP_SUB) begin
                    uword.write_alu  = 1'b1;
                    uword.load_a     = 1'b1;
                    uword.load_flags = 1'b1;
                    uword.subtract   = (opcode_e'(opcode) == OP_SUB);
                end
                uword.end_step = 1'b1;
            end
            default: uword.end_step = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Sequencer top: T-state counter, flag register, halt bit and strobe gating around the microcode ROM.
// Optional CTRL_SINGLE_STEP_EN adds step_mode/step_btn for push-button single stepping.
module control_unit
    import control_unit_pkg::*;
(
    input  logic                clk,
    input  logic                clr,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                carry_in,
    input  logic                zero_in,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic                step_mode,
    input  logic                step_btn,
`endif
    output logic                load_A,
    output logic                load_B,
    output logic                write_A,
    output logic                write_B,
    output logic                write_ALU,
    output logic                subtract,
    output logic                pc_inc,
    output logic                pc_write,
    output logic                jump,
    output logic                mar_load,
    output logic                ram_read,
    output logic                ram_write,
    output logic                ir_load,
    output logic                ir_write,
    output logic                out_load,
    output logic                flag_c,
    output logic                flag_z,
    output logic [STEP_W-1:0]   step,
    output logic                halted
);

    step_e      step_q, step_d;
    logic       halted_d, flag_c_d, flag_z_d;
    logic       advance, active;
    microword_t uword;

`ifdef CTRL_SINGLE_STEP_EN
    logic btn_prev;

    always_ff @(posedge clk) begin
        if (!clr) btn_prev <= 1'b0;
        else      btn_prev <= step_btn;
    end

    assign advance = !step_mode || (step_btn && !btn_prev);
`else
    assign advance = 1'b1;
`endif

    microcode_rom u_rom (
        .opcode (opcode),
        .step   (step_q),
        .flag_c (flag_c),
        .flag_z (flag_z),
        .uword  (uword)
    );

    // Strobes are live only out of reset, out of HALT and on cycles that actually advance.
    assign active = clr && !halted && advance;

    always_comb begin
        step_d   = step_q;
        halted_d = halted;
        flag_c_d = flag_c;
        flag_z_d = flag_z;
        if (active) begin
            if (uword.halt || uword.end_step) begin
                step_d = T0;
            end else begin
                case (step_q)
                    T0:      step_d = T1;
                    T1:      step_d = T2;
                    T2:      step_d = T3;
                    T3:      step_d = T4;
                    default: step_d = T0;
                endcase
            end
            halted_d = uword.halt;
            if (uword.load_flags) begin
                flag_c_d = carry_in;
                flag_z_d = zero_in;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!clr) begin
            step_q <= T0;
            halted <= 1'b0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else begin
            step_q <= step_d;
            halted <= halted_d;
            flag_c <= flag_c_d;
            flag_z <= flag_z_d;
        end
    end

    assign step      = step_q;
    assign load_A    = active & uword.load_a;
    assign load_B    = active & uword.load_b;
    assign write_A   = active & uword.write_a;
    assign write_B   = active & uword.write_b;
    assign write_ALU = active & uword.write_alu;
    assign subtract  = active & uword.subtract;
    assign pc_inc    = active & uword.pc_inc;
    assign pc_write  = active & uword.pc_write;
    assign jump      = active & uword.jump;
    assign mar_load  = active & uword.mar_load;
    assign ram_read  = active & uword.ram_read;
    assign ram_write = active & uword.ram_write;
    assign ir_load   = active & uword.ir_load;
    assign ir_write  = active & uword.ir_write;
    assign out_load  = active & uword.out_load;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected per-cycle strobes/state queued at drive, checked at negedge.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       carry_in = 1'b0;
    logic       zero_in = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
    logic       step_mode = 1'b0;
    logic       step_btn = 1'b0;
`endif
    logic load_A, load_B, write_A, write_B, write_ALU, subtract;
    logic pc_inc, pc_write, jump, mar_load, ram_read, ram_write;
    logic ir_load, ir_write, out_load, flag_c, flag_z, halted;
    logic [2:0] step;

    control_unit dut (
        .clk       (clk),
        .clr       (clr),
        .opcode    (opcode),
        .carry_in  (carry_in),
        .zero_in   (zero_in),
`ifdef CTRL_SINGLE_STEP_EN
        .step_mode (step_mode),
        .step_btn  (step_btn),
`endif
        .load_A    (load_A),
        .load_B    (load_B),
        .write_A   (write_A),
        .write_B   (write_B),
        .write_ALU (write_ALU),
        .subtract  (subtract),
        .pc_inc    (pc_inc),
        .pc_write  (pc_write),
        .jump      (jump),
        .mar_load  (mar_load),
        .ram_read  (ram_read),
        .ram_write (ram_write),
        .ir_load   (ir_load),
        .ir_write  (ir_write),
        .out_load  (out_load),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .step      (step),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Strobe vector order, msb first.
    localparam logic [14:0] S_LOAD_A    = 15'h4000;
    localparam logic [14:0] S_LOAD_B    = 15'h2000;
    localparam logic [14:0] S_WRITE_A   = 15'h1000;
    localparam logic [14:0] S_WRITE_B   = 15'h0800;
    localparam logic [14:0] S_WRITE_ALU = 15'h0400;
    localparam logic [14:0] S_SUBTRACT  = 15'h0200;
    localparam logic [14:0] S_PC_INC    = 15'h0100;
    localparam logic [14:0] S_PC_WRITE  = 15'h0080;
    localparam logic [14:0] S_JUMP      = 15'h0040;
    localparam logic [14:0] S_MAR_LOAD  = 15'h0020;
    localparam logic [14:0] S_RAM_READ  = 15'h0010;
    localparam logic [14:0] S_RAM_WRITE = 15'h0008;
    localparam logic [14:0] S_IR_LOAD   = 15'h0004;
    localparam logic [14:0] S_IR_WRITE  = 15'h0002;
    localparam logic [14:0] S_OUT_LOAD  = 15'h0001;

    wire [14:0] strobes = {load_A, load_B, write_A, write_B, write_ALU, subtract, pc_inc,
                           pc_write, jump, mar_load, ram_read, ram_write, ir_load, ir_write, out_load};

    typedef struct {
        logic [2:0]  step;
        logic [14:0] strobes;
        logic        fc;
        logic        fz;
        logic        halted;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference state of the sequencer.
    int   m_step = 0;
    logic m_fc = 1'b0, m_fz = 1'b0, m_halted = 1'b0, m_btn_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        check("bus_exclusive",
              32'($countones({pc_write, ram_read, write_A, write_B, write_ALU, ir_write}) <= 1), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("step", 32'(step), 32'(e.step));
            check("strobes", 32'(strobes), 32'(e.strobes));
            check("flags", {30'd0, flag_c, flag_z}, {30'd0, e.fc, e.fz});
            check("halted", 32'(halted), 32'(e.halted));
        end
    end

    // Microprogram as a table: strobes, end-of-instruction, halt and flag-load per (opcode, step).
    task automatic decode(input logic [3:0] op, input int t, input logic fc, input logic fz,
                          output logic [14:0] s, output logic fin, output logic hlt, output logic lf);
        s = '0; fin = 1'b0; hlt = 1'b0; lf = 1'b0;
        if (t == 0) s = S_PC_WRITE | S_MAR_LOAD;
        else if (t == 1) s = S_RAM_READ | S_IR_LOAD | S_PC_INC;
        else if (t == 2) begin
            fin = 1'b1;
            case (op)
                4'h1, 4'h2, 4'h3, 4'h4: begin s = S_IR_WRITE | S_MAR_LOAD; fin = 1'b0; end
                4'h5: s = S_IR_WRITE | S_LOAD_A;
                4'h6: s = S_IR_WRITE | S_JUMP;
                4'h7: s = fc ? (S_IR_WRITE | S_JUMP) : 15'h0;
                4'h8: s = fz ? (S_IR_WRITE | S_JUMP) : 15'h0;
                4'hE: s = S_WRITE_A | S_OUT_LOAD;
                4'hF: hlt = 1'b1;
                default: s = 15'h0;
            endcase
        end else if (t == 3) begin
            fin = 1'b1;
            case (op)
                4'h1: s = S_RAM_READ | S_LOAD_A;
                4'h2, 4'h3: begin s = S_RAM_READ | S_LOAD_B; fin = 1'b0; end
                4'h4: s = S_WRITE_A | S_RAM_WRITE;
                default: s = 15'h0;
            endcase
        end else begin
            fin = 1'b1;
            if (op == 4'h2) begin s = S_WRITE_ALU | S_LOAD_A; lf = 1'b1; end
            if (op == 4'h3) begin s = S_WRITE_ALU | S_LOAD_A | S_SUBTRACT; lf = 1'b1; end
        end
    endtask

    // Queue this cycle's expectation from current inputs and model, clock once, then step the model.
    task automatic drive_cycle();
        exp_t        e;
        logic [14:0] s;
        logic        fin, hlt, lf, adv, act;
        adv = 1'b1;
`ifdef CTRL_SINGLE_STEP_EN
        adv = !step_mode || (step_btn && !m_btn_prev);
`endif
        decode(opcode, m_step, m_fc, m_fz, s, fin, hlt, lf);
        act = clr && !m_halted && adv;
        e.step = 3'(m_step);
        e.strobes = act ? s : 15'h0;
        e.fc = m_fc;
        e.fz = m_fz;
        e.halted = m_halted;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
`ifdef CTRL_SINGLE_STEP_EN
        m_btn_prev = clr ? step_btn : 1'b0;
`endif
        if (!clr) begin
            m_step = 0; m_fc = 1'b0; m_fz = 1'b0; m_halted = 1'b0;
        end else if (act) begin
            if (lf) begin m_fc = carry_in; m_fz = zero_in; end
            if (hlt) begin m_halted = 1'b1; m_step = 0; end
            else if (fin) m_step = 0;
            else m_step = m_step + 1;
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input logic cin, input logic zin);
        int n;
        opcode = op; carry_in = cin; zero_in = zin;
        n = 0;
        drive_cycle();
        while (m_step != 0 && n < 8) begin
            drive_cycle();
            n++;
        end
        check("instr_bounded", 32'(n < 8), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        #1;
        clr = 1'b0;
        drive_cycle();
        drive_cycle();
        clr = 1'b1;

        run_instr(4'h2, 1'b1, 1'b0);
        check("add_flag_c", 32'(flag_c), 32'd1);
        check("add_flag_z", 32'(flag_z), 32'd0);
        run_instr(4'h3, 1'b0, 1'b1);
        check("sub_flag_z", 32'(flag_z), 32'd1);
        run_instr(4'h8, 1'b0, 1'b0);
        run_instr(4'h7, 1'b0, 1'b0);
        run_instr(4'h1, 1'b0, 1'b0);
        run_instr(4'h4, 1'b0, 1'b0);
        run_instr(4'h5, 1'b0, 1'b0);
        run_instr(4'hE, 1'b0, 1'b0);
        run_instr(4'h6, 1'b0, 1'b0);
        run_instr(4'h0, 1'b0, 1'b0);
        run_instr(4'hB, 1'b1, 1'b1);
        run_instr(4'h2, 1'b1, 1'b1);
        run_instr(4'h7, 1'b0, 1'b0);

        // HLT then 20 frozen cycles with toggling ALU flags, then leave via reset.
        run_instr(4'hF, 1'b0, 1'b0);
        check("halted_set", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            carry_in = i[0];
            zero_in = ~i[0];
            opcode = 4'(i);
            drive_cycle();
        end
        clr = 1'b0;
        drive_cycle();
        clr = 1'b1;
        check("halt_exit", 32'(halted), 32'd0);
        check("halt_exit_step", 32'(step), 32'd0);

        // Reset during ADD T3 abandons the instruction with no flag update.
        opcode = 4'h2; carry_in = 1'b1; zero_in = 1'b1;
        for (int i = 0; i < 3; i++) drive_cycle();
        check("at_t3", 32'(step), 32'd3);
        clr = 1'b0;
        drive_cycle();
        clr = 1'b1;
        check("abort_step", 32'(step), 32'd0);
        check("abort_flags", {30'd0, flag_c, flag_z}, 32'd0);
        run_instr(4'h0, 1'b0, 1'b0);

`ifdef CTRL_SINGLE_STEP_EN
        step_mode = 1'b1;
        step_btn = 1'b0;
        opcode = 4'h5;
        drive_cycle();
        step_btn = 1'b1;
        for (int i = 0; i < 5; i++) drive_cycle();
        check("single_step_once", 32'(step), 32'd1);
        step_btn = 1'b0;
        step_mode = 1'b0;
        run_instr(4'h5, 1'b0, 1'b0);
`endif

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
